// File: rtl/inner_dot_acc_sched.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | inner_dot_acc_sched: beat sequencer and channel accumulator for the 9-tap  |
// | inner-dot unit. Optional macro INNER_DOT_ACC_RELU_EN clamps results at 0.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module inner_dot_acc_sched #(
  parameter int SUM_WIDTH = 20,
  parameter int ACC_WIDTH = 32,
  parameter int CH_W      = 10
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic        [CH_W-1:0]      cfg_num_ch,
  input  logic signed [ACC_WIDTH-1:0] cfg_bias,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic signed [SUM_WIDTH-1:0] dot_ans,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic signed [ACC_WIDTH-1:0] out_data,
  output logic                        busy
);

  localparam logic [1:0] S_ACC   = 2'd0;
  localparam logic [1:0] S_DRAIN = 2'd1;
  localparam logic [1:0] S_OUT   = 2'd2;

  localparam logic [CH_W-1:0] c_ONE = CH_W'(1);

  logic        [1:0]           r_state;
  logic        [1:0]           w_state_nxt;
  logic        [CH_W-1:0]      r_ch_cnt;
  logic        [CH_W-1:0]      r_num_ch_q;
  logic signed [ACC_WIDTH-1:0] r_acc;
  logic                        r_p_vld;
  logic                        r_p_last;
  logic                        r_out_valid;
  logic signed [ACC_WIDTH-1:0] r_out_data;

  logic                        w_in_ready;
  logic                        w_fire;
  logic                        w_first;
  logic        [CH_W-1:0]      w_cfg_num;
  logic        [CH_W-1:0]      w_eff_num;
  logic                        w_last_beat;
  logic                        w_finish;
  logic signed [ACC_WIDTH-1:0] w_ans_ext;
  logic signed [ACC_WIDTH-1:0] w_sum;
  logic signed [ACC_WIDTH-1:0] w_result;

  assign w_fire      = in_valid & w_in_ready;
  assign w_first     = (r_ch_cnt == '0);
  assign w_cfg_num   = (cfg_num_ch == '0) ? c_ONE : cfg_num_ch;
  assign w_eff_num   = w_first ? w_cfg_num : r_num_ch_q;
  assign w_last_beat = (r_ch_cnt == (w_eff_num - c_ONE));
  assign w_finish    = r_p_vld & r_p_last;
  assign w_ans_ext   = ACC_WIDTH'(dot_ans);
  assign w_sum       = r_acc + w_ans_ext;

`ifdef INNER_DOT_ACC_RELU_EN
  assign w_result = w_sum[ACC_WIDTH-1] ? '0 : w_sum;
`else
  assign w_result = w_sum;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_ACC;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_ACC:   if (w_fire && w_last_beat) w_state_nxt = S_DRAIN;
      S_DRAIN: if (w_finish)              w_state_nxt = S_OUT;
      S_OUT:   if (r_out_valid && out_ready) w_state_nxt = S_ACC;
      default: w_state_nxt = S_ACC;
    endcase
  end

  always_comb begin
    w_in_ready = (r_state == S_ACC);
    busy       = (r_ch_cnt != '0) || (r_state != S_ACC);
  end

  assign in_ready  = w_in_ready;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ch_cnt    <= '0;
      r_num_ch_q  <= c_ONE;
      r_acc       <= '0;
      r_p_vld     <= 1'b0;
      r_p_last    <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
    end else begin
      r_p_vld <= w_fire;
      if (w_fire) begin
        r_p_last <= w_last_beat;
        r_ch_cnt <= w_last_beat ? '0 : (r_ch_cnt + c_ONE);
        if (w_first) r_num_ch_q <= w_cfg_num;
      end

      // Bias load wins over accumulation; both never coincide in practice.
      if (w_fire && w_first)             r_acc <= cfg_bias;
      else if (r_p_vld && !r_p_last)     r_acc <= w_sum;

      if (w_finish) begin
        r_out_data  <= w_result;
        r_out_valid <= 1'b1;
      end else if (r_out_valid && out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_inner_dot_acc_sched.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_inner_dot_acc_sched: directed vector bench for inner_dot_acc_sched.     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_inner_dot_acc_sched;

  localparam int SUM_WIDTH = 20;
  localparam int ACC_WIDTH = 32;
  localparam int CH_W      = 10;
  localparam logic signed [SUM_WIDTH-1:0] c_GARBAGE = 20'sh5A5A5;

  logic                        clk = 1'b0;
  logic                        rst_n;
  logic        [CH_W-1:0]      cfg_num_ch;
  logic signed [ACC_WIDTH-1:0] cfg_bias;
  logic                        in_valid;
  logic                        in_ready;
  logic signed [SUM_WIDTH-1:0] dot_ans;
  logic                        out_valid;
  logic                        out_ready;
  logic signed [ACC_WIDTH-1:0] out_data;
  logic                        busy;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  logic signed [SUM_WIDTH-1:0] pend_ans;

  inner_dot_acc_sched #(
    .SUM_WIDTH(SUM_WIDTH), .ACC_WIDTH(ACC_WIDTH), .CH_W(CH_W)
  ) u_dut (
    .clk(clk), .rst_n(rst_n), .cfg_num_ch(cfg_num_ch), .cfg_bias(cfg_bias),
    .in_valid(in_valid), .in_ready(in_ready), .dot_ans(dot_ans),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int     num;
    int     bias;
    int     a0, a1, a2, a3;
    bit     gaps;
    int     stall;
    bit     cfg_chg;
    longint exp_raw;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string nm, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  function automatic longint model_out(input longint raw);
`ifdef INNER_DOT_ACC_RELU_EN
    return (raw < 0) ? 0 : raw;
`else
    return raw;
`endif
  endfunction

  // Advance one clock; dot unit model returns the launched beat's ans one cycle later.
  task automatic tick();
    logic f;
    f = in_valid && in_ready;
    @(posedge clk);
    #1;
    dot_ans = f ? pend_ans : c_GARBAGE;
    cyc++;
  endtask

  task automatic run_group(input vec_t v, input string nm);
    int     ans[4];
    int     eff;
    int     k;
    int     j;
    int     hold;
    longint exp;
    logic   f;
    ans[0] = v.a0; ans[1] = v.a1; ans[2] = v.a2; ans[3] = v.a3;
    eff = (v.num == 0) ? 1 : v.num;
    exp = model_out(v.exp_raw);
    cfg_num_ch = CH_W'(v.num);
    cfg_bias   = ACC_WIDTH'(v.bias);
    out_ready  = 1'b0;
    k = 0;
    j = 0;
    while (k < eff && j < 50) begin
      in_valid = v.gaps ? ((j % 2) == 0) : 1'b1;
      pend_ans = SUM_WIDTH'(ans[k]);
      f = in_valid && in_ready;
      tick();
      j++;
      if (f) begin
        k++;
        if (k == 1 && v.cfg_chg) begin
          cfg_num_ch = CH_W'(2);
          cfg_bias   = 32'sd999;
        end
        if (k < eff) chk({nm, " busy_mid"}, busy, 1);
      end
    end
    if (k < eff) chk({nm, " beat_timeout"}, k, eff);
    in_valid = 1'b0;
    chk({nm, " ovalid_t+1"}, out_valid, 0);
    chk({nm, " iready_t+1"}, in_ready, 0);
    in_valid = 1'b1;
    tick();
    chk({nm, " ovalid_t+2"}, out_valid, 1);
    chk({nm, " data"}, out_data, exp);
    chk({nm, " iready_t+2"}, in_ready, 0);
    for (int s = 0; s < v.stall; s++) begin
      tick();
      chk({nm, " stall_valid"}, out_valid, 1);
      chk({nm, " stall_data"}, out_data, exp);
      chk({nm, " stall_iready"}, in_ready, 0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    hold = 0;
    tick();
    out_ready = 1'b0;
    chk({nm, " post_ovalid"}, out_valid, hold);
    chk({nm, " post_iready"}, in_ready, 1);
    chk({nm, " post_busy"}, busy, 0);
  endtask

  initial begin
    //          num bias   a0       a1       a2      a3   gap st chg exp
    vecs[0] = '{1,    0,   9,       0,       0,      0,   0, 0, 0, 9};
    vecs[1] = '{4, -100, 145161, 145161, 145161, 145161,  0, 0, 0, 580544};
    vecs[2] = '{3,    7, 100,    -250,     33,      0,    1, 5, 0, -110};
    vecs[3] = '{0,    5, -20,      0,       0,      0,    0, 0, 0, -15};
    vecs[4] = '{4,   10, 1,        2,       3,      4,    0, 0, 1, 20};
    vecs[5] = '{1,  -50, 9,        0,       0,      0,    0, 0, 0, -41};
    vecs[6] = '{2,    1, -524288, 524287,   0,      0,    0, 1, 0, 0};

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    cfg_num_ch = '0; cfg_bias = '0; dot_ans = '0; pend_ans = '0;
    tick(); tick();
    chk("reset out_valid", out_valid, 0);
    chk("reset out_data", out_data, 0);
    chk("reset busy", busy, 0);
    chk("reset in_ready", in_ready, 1);
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 7; i++) begin
      run_group(vecs[i], $sformatf("vec%0d", i));
      tick();
    end

    // Reset after two of four beats: no residue may reach the next group.
    cfg_num_ch = 10'd4; cfg_bias = 32'sd1000;
    in_valid = 1'b1; pend_ans = 20'sd300;
    tick(); tick();
    in_valid = 1'b0;
    chk("midrst busy_before", busy, 1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("midrst out_valid", out_valid, 0);
    chk("midrst out_data", out_data, 0);
    chk("midrst busy", busy, 0);
    chk("midrst in_ready", in_ready, 1);
    run_group(vecs[0], "after_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/inner_dot_acc_sched.md
Name: inner_dot_acc_sched

Overview:
- Sequencer/accumulator for the 9-tap pipelined inner-dot unit: one 3x3 window/weight set per input channel.
- Counts channel beats on a valid/ready input stream and tracks the unit's 1-cycle product-register latency.
- Accumulates the returned dot sums over a configurable channel count, adds a bias and presents one result per output pixel on a valid/ready output.
- Sits between the window/weight fetch logic and the requantisation stage. Data/weight buses go straight from the source to the dot unit; this block only handshakes and consumes the dot unit's ans.

Parameters:
SUM_WIDTH, 20, width of dot-unit ans input (signed)
ACC_WIDTH, 32, accumulator and output width (signed); ACC_WIDTH >= SUM_WIDTH
CH_W, 10, width of channel-count config

Ports:
clk  in  1  clock
rst_n  in  1  reset; synchronous, active-low
cfg_num_ch  in  CH_W  channels per output pixel; sampled on first beat of a group
cfg_bias  in  ACC_WIDTH  signed bias; sampled on first beat of a group
in_valid  in  1  source presents one channel's window+weights to the dot unit this cycle
in_ready  out  1  block accepts beat (fire = in_valid & in_ready)
dot_ans  in  SUM_WIDTH  signed ans from dot unit; valid 1 cycle after the fire that launched it
out_valid  out  1  result valid
out_ready  in  1  downstream accepts result
out_data  out  ACC_WIDTH  signed accumulated result incl. bias
busy  out  1  group in progress (ch_cnt != 0 or state != S_ACC)

Behaviour:
- Clock/reset: single clock clk. rst_n is synchronous, active-low.
- Reset values: state=S_ACC, ch_cnt=0, num_ch_q=1, acc=0, p_vld=0, p_last=0, out_valid=0, out_data=0, busy=0. Reset mid-group discards all partial state; a beat already in the dot unit is ignored.
- States:
  - S_ACC: in_ready=1.
  - S_DRAIN: in_ready=0; one cycle, waits for the last ans.
  - S_OUT: in_ready=0; holds the result.
- On fire with ch_cnt==0:
  - num_ch_q <= (cfg_num_ch==0 ? 1 : cfg_num_ch).
  - acc <= cfg_bias.
  - Config changes at any other time have no effect on the current group.
- On each fire:
  - p_vld <= 1; p_last <= (ch_cnt == eff_num-1), where eff_num is the freshly computed value on the first beat, num_ch_q otherwise.
  - ch_cnt increments.
  - On the last beat, ch_cnt <= 0 and state -> S_DRAIN.
  - With no fire, p_vld <= 0.
- Accumulate: when p_vld=1 and p_last=0, acc <= acc + sext(dot_ans). If the same cycle is the first fire of a new group, the bias load has priority; this is unreachable by construction, since groups are separated by S_DRAIN/S_OUT.
- Finish: when p_vld=1 and p_last=1 (always the S_DRAIN cycle):
  - out_data <= acc + sext(dot_ans).
  - out_valid <= 1.
  - state -> S_OUT.
- S_OUT: out_data/out_valid held stable while out_ready=0. On out_valid & out_ready: out_valid <= 0, state -> S_ACC. in_ready rises the following cycle.
- Latency: last fire at cycle t -> out_valid=1 at t+2. Minimum group period is eff_num+2 cycles with out_ready held high.
- Gaps: in_valid low in S_ACC inserts bubbles. p_vld=0 keeps acc unchanged. The dot unit's garbage ans is ignored.
- Arithmetic: two's-complement, dot_ans sign-extended to ACC_WIDTH. Overflow wraps modulo 2^ACC_WIDTH; no flag.
- busy=1 from the first fire of a group until the output handshake completes.

Optional Feature:
- Macro: INNER_DOT_ACC_RELU_EN.
- Defined: the finish step loads out_data <= max(0, acc + sext(dot_ans)), i.e. a negative sum gives 0. Applied only at the output; the accumulator is unaffected.
- Undefined: out_data is the raw signed sum.
- Latency is identical in both builds.

Test Plan:
- Single channel: cfg_num_ch=1, bias=0, data=1, weights=1 (dot ans=9), one fire at t -> out_valid at t+2, out_data=9; in_ready low at t+1..t+2, high the cycle after the out handshake.
- Four channels: cfg_num_ch=4, bias=-100, all data=127, weights=127 (ans=145161 each), back-to-back fires -> out_data=580544, out_valid exactly 2 cycles after the 4th fire.
- Backpressure and gaps: cfg_num_ch=3 with in_valid toggling 1,0,1,0,1; out_ready low 5 cycles -> sum of 3 ans correct; out_data stable and in_ready=0 throughout the stall; no beat accepted until the handshake.
- Config edge cases: cfg_num_ch=0 -> group of 1. cfg_num_ch changed 4->2 and cfg_bias changed after the first beat -> group still 4 beats with the original bias.
- Reset mid-group: rst_n low one cycle after 2 of 4 beats -> all outputs 0 next cycle; a following 1-channel group with ans=9, bias=0 gives 9, with no residue.
- ReLU: cfg_num_ch=1, bias=-50, ans=9 -> out_data=0 with INNER_DOT_ACC_RELU_EN defined, -41 without.
